// File: rtl/fma_disp_pkg.sv
// fma_disp_pkg: shared constants for the FMA display sequencer.
// Holds source codes, the sequencer state encoding and the default dwell time.
package fma_disp_pkg;

    localparam logic [1:0] SRC_A   = 2'd0;
    localparam logic [1:0] SRC_B   = 2'd1;
    localparam logic [1:0] SRC_C   = 2'd2;
    localparam logic [1:0] SRC_RES = 2'd3;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    // 2 s at 100 MHz
    localparam int unsigned DWELL_CYCLES_DEFAULT = 200_000_000;

endpackage

// File: rtl/disp_tick_timer.sv
// disp_tick_timer: counts enabled cycles and pulses tick on the TC-th one.
// Ports: clock_100Mhz, reset (sync, high), clear (count <= 0),
//        enable (count this cycle), tick (count == TC-1 while enabled).
module disp_tick_timer #(
    parameter int unsigned TC = 2
) (
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned W = (TC > 1) ? $clog2(TC) : 1;
    localparam logic [W-1:0] LAST = W'(TC - 1);

    logic [W-1:0] count_q;

    assign tick = enable && (count_q == LAST);

    always_ff @(posedge clock_100Mhz) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/fma_display_sequencer.sv
// fma_display_sequencer: picks operand A/B/C or the FMA result for the hex
// display, from a snapshot taken on each fma_valid strobe.
// Ports: clock_100Mhz, reset (sync, high); op_a/op_b/op_c/fma_result and
//        fma_valid (snapshot strobe); btn_next, btn_mode (debounced pulses);
//        display_word, src_sel, src_led (one-hot), auto_mode, blank.
// Optional: define FMA_DISPLAY_BLINK_NEW_EN to blink the display after a
//           new result; otherwise blank is tied low.
module fma_display_sequencer
    import fma_disp_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEFAULT,
    parameter int unsigned BLINK_CYCLES = 25_000_000,
    parameter int unsigned BLINK_PAIRS  = 3
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [15:0] op_c,
    input  logic [15:0] fma_result,
    input  logic        fma_valid,
    input  logic        btn_next,
    input  logic        btn_mode,
    output logic [15:0] display_word,
    output logic [1:0]  src_sel,
    output logic [3:0]  src_led,
    output logic        auto_mode,
    output logic        blank
);

    state_t      state_q, state_d;
    logic [1:0]  src_q, src_d;
    logic [15:0] shadow_q [4];
    logic        dwell_tick;

    // Counter sits at 0 in MANUAL; any strobe or button advance restarts it.
    disp_tick_timer #(
        .TC(DWELL_CYCLES)
    ) u_dwell_timer (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .clear       ((state_q == ST_MANUAL) || fma_valid || btn_next),
        .enable      (state_q == ST_AUTO),
        .tick        (dwell_tick)
    );

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q <= ST_MANUAL;
            src_q   <= SRC_RES;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
        end
    end

    // fma_valid beats btn_next beats expiry; btn_mode acts on its own.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        if (btn_mode) begin
            state_d = (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
        end
        if (fma_valid) begin
            src_d = SRC_RES;
        end else if (btn_next || dwell_tick) begin
            src_d = src_q + 2'd1;
        end
    end

    // All four words captured together so the display never mixes results.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 16'h0000;
            end
        end else if (fma_valid) begin
            shadow_q[SRC_A]   <= op_a;
            shadow_q[SRC_B]   <= op_b;
            shadow_q[SRC_C]   <= op_c;
            shadow_q[SRC_RES] <= fma_result;
        end
    end

    assign display_word = shadow_q[src_q];
    assign src_sel      = src_q;
    assign src_led      = 4'b0001 << src_q;
    assign auto_mode    = (state_q == ST_AUTO);

`ifdef FMA_DISPLAY_BLINK_NEW_EN
    localparam int unsigned SEGS = 2 * BLINK_PAIRS;
    localparam int unsigned SW   = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam logic [SW-1:0] LAST_SEG = SW'(SEGS - 1);

    logic          blink_active_q;
    logic          blank_q;
    logic [SW-1:0] seg_q;
    logic          blink_tick;

    disp_tick_timer #(
        .TC(BLINK_CYCLES)
    ) u_blink_timer (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .clear       (fma_valid || !blink_active_q),
        .enable      (blink_active_q),
        .tick        (blink_tick)
    );

    // Segment 0 is blanked; each half-period flips blank until the last.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            blink_active_q <= 1'b0;
            blank_q        <= 1'b0;
            seg_q          <= '0;
        end else if (fma_valid) begin
            blink_active_q <= 1'b1;
            blank_q        <= 1'b1;
            seg_q          <= '0;
        end else if (blink_tick) begin
            if (seg_q == LAST_SEG) begin
                blink_active_q <= 1'b0;
                blank_q        <= 1'b0;
            end else begin
                seg_q   <= seg_q + SW'(1);
                blank_q <= ~blank_q;
            end
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_fma_display_sequencer.sv
// tb_fma_display_sequencer: directed checks of snapshot, MANUAL/AUTO stepping,
// event priority, reset abort and (when enabled) the new-result blink.
module tb_fma_display_sequencer;

    localparam int DW = 8;
    localparam int BC = 4;
    localparam int BP = 3;

    logic        clock_100Mhz = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] op_c = '0;
    logic [15:0] fma_result = '0;
    logic        fma_valid = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_mode = 1'b0;
    logic [15:0] display_word;
    logic [1:0]  src_sel;
    logic [3:0]  src_led;
    logic        auto_mode;
    logic        blank;

    int n_total = 0;
    int n_bad   = 0;

    fma_display_sequencer #(
        .DWELL_CYCLES(DW),
        .BLINK_CYCLES(BC),
        .BLINK_PAIRS (BP)
    ) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_c        (op_c),
        .fma_result  (fma_result),
        .fma_valid   (fma_valid),
        .btn_next    (btn_next),
        .btn_mode    (btn_mode),
        .display_word(display_word),
        .src_sel     (src_sel),
        .src_led     (src_led),
        .auto_mode   (auto_mode),
        .blank       (blank)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_100Mhz);
        #1;
    endtask

    task automatic pulse(input logic fv, input logic bn, input logic bm);
        fma_valid = fv;
        btn_next  = bn;
        btn_mode  = bm;
        step();
        fma_valid = 1'b0;
        btn_next  = 1'b0;
        btn_mode  = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] r);
        op_a       = a;
        op_b       = b;
        op_c       = c;
        fma_result = r;
    endtask

    // Expects counter at 0 on entry: DW-1 holds, then one advance.
    task automatic dwell(input logic [1:0] from, input logic [1:0] to,
                         input string tag);
        for (int i = 0; i < DW - 1; i++) begin
            step();
            check({tag, "_hold"}, 16'(src_sel), 16'(from));
        end
        step();
        check({tag, "_adv"}, 16'(src_sel), 16'(to));
    endtask

    function automatic logic blink_exp(input int k);
`ifdef FMA_DISPLAY_BLINK_NEW_EN
        return (k < 2 * BP * BC) && (((k / BC) % 2) == 0);
`else
        return 1'b0;
`endif
    endfunction

    logic [15:0] exp_word [4];

    initial begin
        // reset state, held with no strobe
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check("rst_word", display_word, 16'h0000);
            check("rst_src", 16'(src_sel), 16'd3);
            check("rst_led", 16'(src_led), 16'b1000);
            check("rst_auto", 16'(auto_mode), 16'd0);
            check("rst_blank", 16'(blank), 16'd0);
        end

        // snapshot, then inputs change without a strobe
        load(16'h3F80, 16'h4000, 16'h3F00, 16'h4020);
        pulse(1'b1, 1'b0, 1'b0);
        check("snap_src", 16'(src_sel), 16'd3);
        check("snap_res", display_word, 16'h4020);
        load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        exp_word[0] = 16'h3F80;
        exp_word[1] = 16'h4000;
        exp_word[2] = 16'h3F00;
        exp_word[3] = 16'h4020;
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            check("man_src", 16'(src_sel), 16'(i));
            check("man_word", display_word, exp_word[i]);
            check("man_led", 16'(src_led), 16'(4'b0001 << i));
        end

        // AUTO stepping
        pulse(1'b0, 1'b0, 1'b1);
        check("auto_on", 16'(auto_mode), 16'd1);
        check("auto_src", 16'(src_sel), 16'd3);
        dwell(2'd3, 2'd0, "auto30");
        check("auto_w0", display_word, 16'h3F80);
        dwell(2'd0, 2'd1, "auto01");
        dwell(2'd1, 2'd2, "auto12");
        dwell(2'd2, 2'd3, "auto23");
        for (int i = 0; i < 5; i++) step();
        check("auto_pre_btn", 16'(src_sel), 16'd3);
        pulse(1'b0, 1'b1, 1'b0);
        check("auto_btn", 16'(src_sel), 16'd0);
        dwell(2'd0, 2'd1, "auto_after_btn");

        // strobe with btn_next on a dwell expiry edge
        for (int i = 0; i < DW - 1; i++) step();
        check("coinc_pre", 16'(src_sel), 16'd1);
        load(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        pulse(1'b1, 1'b1, 1'b0);
        check("coinc_src", 16'(src_sel), 16'd3);
        check("coinc_word", display_word, 16'h4444);
        check("coinc_auto", 16'(auto_mode), 16'd1);
        dwell(2'd3, 2'd0, "coinc_dwell");
        check("coinc_w0", display_word, 16'h1111);

        // mode toggle with a strobe
        load(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        pulse(1'b1, 1'b0, 1'b1);
        check("mode_fv_auto", 16'(auto_mode), 16'd0);
        check("mode_fv_src", 16'(src_sel), 16'd3);
        check("mode_fv_word", display_word, 16'hDDDD);
        for (int i = 0; i < 20; i++) step();
        check("manual_hold", 16'(src_sel), 16'd3);

        // reset mid-AUTO
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("pre_rst_src", 16'(src_sel), 16'd1);
        check("pre_rst_auto", 16'(auto_mode), 16'd1);
        check("pre_rst_word", display_word, 16'hBBBB);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_src", 16'(src_sel), 16'd3);
        check("mid_rst_auto", 16'(auto_mode), 16'd0);
        check("mid_rst_word", display_word, 16'h0000);
        check("mid_rst_led", 16'(src_led), 16'b1000);
        check("mid_rst_blank", 16'(blank), 16'd0);
        pulse(1'b0, 1'b1, 1'b0);
        check("post_rst_a", display_word, 16'h0000);
        for (int i = 0; i < 12; i++) step();
        check("post_rst_hold", 16'(src_sel), 16'd0);

        // new-result blink, buttons pressed along the way
        load(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        pulse(1'b1, 1'b0, 1'b0);
        check("blink_k0", 16'(blank), 16'(blink_exp(0)));
        for (int k = 1; k < 30; k++) begin
            pulse(1'b0, k == 10, k == 14);
            check("blink_seq", 16'(blank), 16'(blink_exp(k)));
        end

        // restart from a blank-off segment
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 6; k++) begin
            step();
            check("blink_pre", 16'(blank), 16'(blink_exp(k)));
        end
        pulse(1'b1, 1'b0, 1'b0);
        check("restart_k0", 16'(blank), 16'(blink_exp(0)));
        for (int k = 1; k < 28; k++) begin
            step();
            check("restart_seq", 16'(blank), 16'(blink_exp(k)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
